// File: rtl/score_pkg.sv
// score_pkg: shared encodings for the pong score keeper.
// FSM state codes, winner codes, score width and small helpers.
package score_pkg;

   localparam int SCORE_W = 10;

   typedef logic [1:0] state_t;
   typedef logic [1:0] winner_t;

   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_PLAY    = 2'd1;
   localparam state_t ST_HOLDOFF = 2'd2;
   localparam state_t ST_WIN     = 2'd3;

   localparam winner_t WIN_NONE = 2'b00;
   localparam winner_t WIN_P1   = 2'b01;
   localparam winner_t WIN_P2   = 2'b10;

   // Counter width wide enough for the larger of two frame counts.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m + 1);
   endfunction

   // Increment that sticks at lim instead of wrapping.
   function automatic logic [SCORE_W-1:0] sat_inc(
      input logic [SCORE_W-1:0] v,
      input logic [SCORE_W-1:0] lim
   );
      return (v >= lim) ? lim : v + SCORE_W'(1);
   endfunction

endpackage

// File: rtl/rise_detect.sv
// rise_detect: one-register rising-edge detector.
// Ports: clock, resetn (async active-low), d_i level in, rise_o = d_i & ~d_q.
module rise_detect (
   input  logic clock,
   input  logic resetn,
   input  logic d_i,
   output logic rise_o
);

   logic d_q;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) d_q <= 1'b0;
      else         d_q <= d_i;
   end

   assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/score_keeper.sv
// score_keeper: pong score counts, winner detection and serve pacing.
// Ports: clock, resetn (async low), frame_tick, goal_left, goal_right, menu in;
//   score1/score2 (10b), winner (2b), game_over, serve, playing out.
// Build option: SCORE_AUTO_RESTART_EN restarts the game RESTART_FRAMES
//   frames after a win; undefined, WIN holds until menu.
module score_keeper
   import score_pkg::*;
#(
   parameter int unsigned WIN_SCORE      = 9,
   parameter int unsigned HOLDOFF_FRAMES = 60,
   parameter int unsigned RESTART_FRAMES = 180
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               frame_tick,
   input  logic               goal_left,
   input  logic               goal_right,
   input  logic               menu,
   output logic [SCORE_W-1:0] score1,
   output logic [SCORE_W-1:0] score2,
   output logic [1:0]         winner,
   output logic               game_over,
   output logic               serve,
   output logic               playing
);

   localparam int CNT_W = cnt_width(HOLDOFF_FRAMES, RESTART_FRAMES);
   localparam logic [SCORE_W-1:0] WIN_C  = SCORE_W'(WIN_SCORE);
   localparam logic [CNT_W-1:0]   HOLD_C = CNT_W'(HOLDOFF_FRAMES);
`ifdef SCORE_AUTO_RESTART_EN
   localparam logic [CNT_W-1:0]   RST_C  = CNT_W'(RESTART_FRAMES);
`endif

   state_t             state_q, state_d;
   logic [SCORE_W-1:0] s1_q, s1_d;
   logic [SCORE_W-1:0] s2_q, s2_d;
   winner_t            win_q, win_d;
   logic               serve_q, serve_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic gl_rise;
   logic gr_rise;
   logic menu_fall;

   rise_detect u_gl (
      .clock  (clock),
      .resetn (resetn),
      .d_i    (goal_left),
      .rise_o (gl_rise)
   );

   rise_detect u_gr (
      .clock  (clock),
      .resetn (resetn),
      .d_i    (goal_right),
      .rise_o (gr_rise)
   );

   // Falling edge of menu is a rising edge of its complement.
   rise_detect u_menu (
      .clock  (clock),
      .resetn (resetn),
      .d_i    (~menu),
      .rise_o (menu_fall)
   );

   always_comb begin
      state_d = state_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      win_d   = win_q;
      serve_d = 1'b0;
      cnt_d   = cnt_q;
      if (menu) begin
         // Menu wins over everything; scores stay for the renderer.
         state_d = ST_IDLE;
         win_d   = WIN_NONE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (menu_fall) begin
                  s1_d    = '0;
                  s2_d    = '0;
                  win_d   = WIN_NONE;
                  cnt_d   = '0;
                  serve_d = 1'b1;
                  state_d = ST_PLAY;
               end
            end
            ST_PLAY: begin
               // Both goals in one cycle is a glitch: ignore.
               if (gl_rise ^ gr_rise) begin
                  if (gr_rise) s1_d = sat_inc(s1_q, WIN_C);
                  else         s2_d = sat_inc(s2_q, WIN_C);
                  cnt_d = '0;
                  if (gr_rise && s1_d == WIN_C) begin
                     state_d = ST_WIN;
                     win_d   = WIN_P1;
                  end else if (gl_rise && s2_d == WIN_C) begin
                     state_d = ST_WIN;
                     win_d   = WIN_P2;
                  end else begin
                     state_d = ST_HOLDOFF;
                  end
               end
            end
            ST_HOLDOFF: begin
               if (frame_tick) begin
                  cnt_d = cnt_q + CNT_W'(1);
                  if (cnt_d == HOLD_C) begin
                     serve_d = 1'b1;
                     state_d = ST_PLAY;
                  end
               end
            end
            ST_WIN: begin
`ifdef SCORE_AUTO_RESTART_EN
               if (frame_tick) begin
                  cnt_d = cnt_q + CNT_W'(1);
                  if (cnt_d == RST_C) begin
                     s1_d    = '0;
                     s2_d    = '0;
                     win_d   = WIN_NONE;
                     cnt_d   = '0;
                     serve_d = 1'b1;
                     state_d = ST_PLAY;
                  end
               end
`endif
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         s1_q    <= '0;
         s2_q    <= '0;
         win_q   <= WIN_NONE;
         serve_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         win_q   <= win_d;
         serve_q <= serve_d;
         cnt_q   <= cnt_d;
      end
   end

   assign score1    = s1_q;
   assign score2    = s2_q;
   assign winner    = win_q;
   assign serve     = serve_q;
   assign game_over = (state_q == ST_WIN);
   assign playing   = (state_q == ST_PLAY);

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: vector table, hand sequences and a random run
// checked against a behavioural scoring model.
module tb_score_keeper;

   localparam int WIN  = 9;
   localparam int HOLD = 60;
   localparam int RST  = 180;

   logic       clock = 1'b0;
   logic       resetn;
   logic       frame_tick, goal_left, goal_right, menu;
   logic [9:0] score1, score2;
   logic [1:0] winner;
   logic       game_over, serve, playing;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   score_keeper #(
      .WIN_SCORE      (WIN),
      .HOLDOFF_FRAMES (HOLD),
      .RESTART_FRAMES (RST)
   ) dut (
      .clock      (clock),
      .resetn     (resetn),
      .frame_tick (frame_tick),
      .goal_left  (goal_left),
      .goal_right (goal_right),
      .menu       (menu),
      .score1     (score1),
      .score2     (score2),
      .winner     (winner),
      .game_over  (game_over),
      .serve      (serve),
      .playing    (playing)
   );

   // Behavioural model: game phase plus frames remaining.
   localparam int P_IDLE = 0, P_PLAY = 1, P_WAIT = 2, P_WON = 3;
   int m_phase, m_s1, m_s2, m_win, m_left;
   bit m_serve, m_pgl, m_pgr, m_pmenu;

   function automatic void m_reset();
      m_phase = P_IDLE; m_s1 = 0; m_s2 = 0; m_win = 0;
      m_left = 0; m_serve = 0; m_pgl = 0; m_pgr = 0;
      m_pmenu = 1;  // reset looks like leaving the menu was pending
   endfunction

   function automatic void m_step(bit t, bit gl, bit gr, bit mn);
      bit rl, rr, fall;
      rl = gl && !m_pgl;
      rr = gr && !m_pgr;
      fall = !mn && m_pmenu;
      m_serve = 0;
      if (mn) begin
         m_phase = P_IDLE; m_win = 0;
      end else begin
         case (m_phase)
            P_IDLE: if (fall) begin
               m_s1 = 0; m_s2 = 0; m_win = 0;
               m_serve = 1; m_phase = P_PLAY;
            end
            P_PLAY: if (rl != rr) begin
               if (rr) m_s1 = m_s1 + 1; else m_s2 = m_s2 + 1;
               if (m_s1 == WIN) begin
                  m_phase = P_WON; m_win = 1; m_left = RST;
               end else if (m_s2 == WIN) begin
                  m_phase = P_WON; m_win = 2; m_left = RST;
               end else begin
                  m_phase = P_WAIT; m_left = HOLD;
               end
            end
            P_WAIT: if (t) begin
               m_left = m_left - 1;
               if (m_left == 0) begin m_serve = 1; m_phase = P_PLAY; end
            end
            default: begin
`ifdef SCORE_AUTO_RESTART_EN
               if (t) begin
                  m_left = m_left - 1;
                  if (m_left == 0) begin
                     m_s1 = 0; m_s2 = 0; m_win = 0;
                     m_serve = 1; m_phase = P_PLAY;
                  end
               end
`endif
            end
         endcase
      end
      m_pgl = gl; m_pgr = gr; m_pmenu = mn;
   endfunction

   task automatic drive(input logic t, input logic gl, input logic gr, input logic mn);
      frame_tick = t; goal_left = gl; goal_right = gr; menu = mn;
      @(posedge clock);
      m_step(t, gl, gr, mn);
      #1;
   endtask

   task automatic chk(input string nm, input logic [9:0] e1, input logic [9:0] e2,
                      input logic [1:0] ew, input logic ego, input logic esv, input logic epl);
      checks++;
      if ({score1, score2, winner, game_over, serve, playing} !==
          {e1, e2, ew, ego, esv, epl}) begin
         errors++;
         $display("FAIL %s: got s1=%0d s2=%0d w=%b go=%b sv=%b pl=%b want s1=%0d s2=%0d w=%b go=%b sv=%b pl=%b",
                  nm, score1, score2, winner, game_over, serve, playing,
                  e1, e2, ew, ego, esv, epl);
      end
   endtask

   task automatic chk_val(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", nm, got, exp);
      end
   endtask

   task automatic chk_model(input string nm);
      chk(nm, 10'(m_s1), 10'(m_s2), 2'(m_win), m_phase == P_WON,
          m_serve, m_phase == P_PLAY);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      frame_tick = 0; goal_left = 0; goal_right = 0; menu = 1;
      m_reset();
      repeat (2) @(posedge clock);
      #1;
      chk("reset", 0, 0, 2'b00, 0, 0, 0);
      @(negedge clock);
      resetn = 1'b1;
   endtask

   // Goal then tick every cycle until the serve, bounded.
   task automatic score_goal(input logic left);
      bit got;
      drive(0, left, !left, 0);
      got = 0;
      for (int k = 0; k < 100 && !got; k++) begin
         drive(1, 0, 0, 0);
         if (serve) got = 1;
      end
      chk_val("serve_timeout", int'(got), 1);
   endtask

   typedef struct {
      logic t, gl, gr, mn;
      int   s1, s2;
      logic [1:0] w;
      logic go, sv, pl;
   } vec_t;

   vec_t tbl[20];

   initial begin
      int nt, serves, serve_nt;
      logic rgl, rgr, rmn, rt;
      int mhold;

      tbl[0]  = '{0,0,0,1, 0,0,2'b00,0,0,0};
      tbl[1]  = '{0,0,0,0, 0,0,2'b00,0,1,1};
      tbl[2]  = '{0,0,0,0, 0,0,2'b00,0,0,1};
      tbl[3]  = '{0,0,1,0, 1,0,2'b00,0,0,0};
      tbl[4]  = '{0,0,1,0, 1,0,2'b00,0,0,0};
      tbl[5]  = '{0,1,0,0, 1,0,2'b00,0,0,0};
      tbl[6]  = '{1,1,0,0, 1,0,2'b00,0,0,0};
      tbl[7]  = '{0,1,0,1, 1,0,2'b00,0,0,0};
      tbl[8]  = '{0,0,0,0, 0,0,2'b00,0,1,1};
      tbl[9]  = '{0,1,1,0, 0,0,2'b00,0,0,1};
      tbl[10] = '{0,0,0,0, 0,0,2'b00,0,0,1};
      tbl[11] = '{0,1,0,0, 0,1,2'b00,0,0,0};
      tbl[12] = '{0,0,0,1, 0,1,2'b00,0,0,0};
      tbl[13] = '{0,1,0,1, 0,1,2'b00,0,0,0};
      tbl[14] = '{0,1,0,0, 0,0,2'b00,0,1,1};
      tbl[15] = '{0,1,0,0, 0,0,2'b00,0,0,1};
      tbl[16] = '{0,0,0,0, 0,0,2'b00,0,0,1};
      tbl[17] = '{0,0,1,1, 0,0,2'b00,0,0,0};
      tbl[18] = '{0,0,1,0, 0,0,2'b00,0,1,1};
      tbl[19] = '{0,0,0,0, 0,0,2'b00,0,0,1};

      do_reset();
      for (int i = 0; i < 20; i++) begin
         drive(tbl[i].t, tbl[i].gl, tbl[i].gr, tbl[i].mn);
         chk($sformatf("vec%0d", i), 10'(tbl[i].s1), 10'(tbl[i].s2),
             tbl[i].w, tbl[i].go, tbl[i].sv, tbl[i].pl);
      end

      // Held goal: counted once, serve on the 60th tick.
      nt = 0; serves = 0; serve_nt = -1;
      for (int i = 0; i < 200; i++) begin
         rt = (i > 0) && (i % 3 == 0);
         drive(rt, 0, 1, 0);
         if (rt) nt++;
         if (serve) begin serves++; serve_nt = nt; end
      end
      chk_val("holdoff_serves", serves, 1);
      chk_val("holdoff_ticks", serve_nt, HOLD);
      chk("held_goal", 1, 0, 2'b00, 0, 0, 1);
      drive(0, 0, 0, 0);

      // Mid-game async reset.
      score_goal(0);
      score_goal(0);
      chk_val("mid_s1", int'(score1), 3);
      #2;
      resetn = 1'b0;
      menu = 1;
      m_reset();
      #1;
      chk("reset_async", 0, 0, 2'b00, 0, 0, 0);
      @(negedge clock);
      resetn = 1'b1;

      // Player 2 wins.
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 0);
      chk("start", 0, 0, 2'b00, 0, 1, 1);
      for (int g = 0; g < 8; g++) score_goal(1);
      chk_val("s2_eight", int'(score2), 8);
      drive(0, 1, 0, 0);
      chk("win_p2", 0, 9, 2'b10, 1, 0, 0);
      drive(0, 0, 0, 0);
      drive(0, 0, 1, 0);
      drive(0, 0, 0, 0);
      drive(0, 1, 0, 0);
      chk("win_frozen", 0, 9, 2'b10, 1, 0, 0);
      drive(0, 0, 0, 0);
      nt = 0; serves = 0; serve_nt = -1;
      for (int i = 0; i < 190; i++) begin
         drive(1, 0, 0, 0);
         nt++;
         if (serve) begin serves++; serve_nt = nt; end
      end
`ifdef SCORE_AUTO_RESTART_EN
      chk_val("restart_serves", serves, 1);
      chk_val("restart_ticks", serve_nt, RST);
      chk("restarted", 0, 0, 2'b00, 0, 0, 1);
      drive(0, 0, 0, 1);
      chk("menu_exit", 0, 0, 2'b00, 0, 0, 0);
`else
      chk_val("win_no_serve", serves, 0);
      chk("win_held", 0, 9, 2'b10, 1, 0, 0);
      drive(0, 0, 0, 1);
      chk("menu_exit", 0, 9, 2'b00, 0, 0, 0);
`endif

      // Random traffic against the model.
      do_reset();
      rgl = 0; rgr = 0; rmn = 1; mhold = 2;
      for (int i = 0; i < 6000; i++) begin
         rt = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 7) == 0) rgl = ~rgl;
         if ($urandom_range(0, 7) == 0) rgr = ~rgr;
         if (mhold > 0) begin
            rmn = 1; mhold--;
         end else begin
            rmn = 0;
            if ($urandom_range(0, 499) == 0) mhold = $urandom_range(1, 4);
         end
         drive(rt, rgl, rgr, rmn);
         chk_model("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
